audio_delay_line: RTL and testbench

AUDIO_DELAY_LINE -- requirements
Module: audio_delay_line

---
 rtl/audio_pkg.sv | 27 ++
 rtl/delay_ram.sv | 25 ++
 rtl/audio_delay_line.sv | 158 +++++++++++++++
 tb/tb_audio_delay_line.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and arithmetic for the audio delay line: fill-state encoding and
// a width-generic saturating signed adder.
package audio_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FILLING,
    ST_FULL
  } fill_state_t;

  // Operands arrive sign-extended to 32 bits; the result is clamped to the
  // signed range of 'width' bits and returned sign-extended in 33 bits.
  function automatic logic signed [32:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int width);
    logic signed [32:0] sum;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    sum = 33'(a) + 33'(b);
    hi  = (33'sd1 <<< (width - 1)) - 33'sd1;
    lo  = -(33'sd1 <<< (width - 1));
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/delay_ram.sv
// Simple dual-port frame memory: one write port, one registered read port.
// A read of the address being written returns the previous contents.
module delay_ram #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/audio_delay_line.sv
// Multichannel circular-buffer audio delay with fill tracking and a fixed
// two-cycle latency. Define AUDIO_DELAY_ECHO_EN to mix dry + scaled delayed signal.
module audio_delay_line
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int CHANNELS   = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  input  logic [ADDR_WIDTH-1:0]          delay,
  input  logic                           flush,
`ifdef AUDIO_DELAY_ECHO_EN
  input  logic [3:0]                     echo_shift,
`endif
  output logic                           out_valid,
  output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
  output logic                           primed,
  output logic [ADDR_WIDTH:0]            fill_level
);

  localparam int FW = CHANNELS * DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_LEVEL = {1'b1, {ADDR_WIDTH{1'b0}}};

  fill_state_t           state;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [FW-1:0]         rd_data;
  logic                  primed_now;

  // Stage-1 registers travel alongside the registered RAM read.
  logic                  s1_valid;
  logic                  s1_bypass;
  logic                  s1_primed;
  logic [FW-1:0]         s1_dry;
  logic [3:0]            s1_shift;
  logic [FW-1:0]         mix_frame;

  assign rd_addr = wr_ptr - delay;

  // A flush in the same cycle means this frame sees an empty buffer.
  assign primed_now = flush ? (delay == '0) : ({1'b0, delay} <= fill_level);

  delay_ram #(
    .WIDTH      (FW),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (in_valid),
    .waddr (wr_ptr),
    .wdata (in_data),
    .re    (in_valid),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (in_valid) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_EMPTY;
      fill_level <= '0;
    end else if (flush) begin
      if (in_valid) begin
        fill_level <= {{ADDR_WIDTH{1'b0}}, 1'b1};
        state      <= (ADDR_WIDTH == 0) ? ST_FULL : ST_FILLING;
      end else begin
        fill_level <= '0;
        state      <= ST_EMPTY;
      end
    end else if (in_valid) begin
      case (state)
        ST_EMPTY: begin
          fill_level <= {{ADDR_WIDTH{1'b0}}, 1'b1};
          state      <= (ADDR_WIDTH == 0) ? ST_FULL : ST_FILLING;
        end
        ST_FILLING: begin
          fill_level <= fill_level + 1'b1;
          if (fill_level + 1'b1 == FULL_LEVEL) state <= ST_FULL;
        end
        default: begin
          fill_level <= FULL_LEVEL;
          state      <= ST_FULL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_bypass <= 1'b0;
      s1_primed <= 1'b0;
      s1_dry    <= '0;
      s1_shift  <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_bypass <= (delay == '0);
        s1_primed <= primed_now;
        s1_dry    <= in_data;
`ifdef AUDIO_DELAY_ECHO_EN
        s1_shift  <= echo_shift;
`else
        s1_shift  <= '0;
`endif
      end
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic signed [DATA_WIDTH-1:0] dry;
    logic signed [DATA_WIDTH-1:0] delayed;
    logic signed [DATA_WIDTH-1:0] mixed;

    assign dry     = s1_dry[gi*DATA_WIDTH +: DATA_WIDTH];
    assign delayed = s1_bypass ? dry : rd_data[gi*DATA_WIDTH +: DATA_WIDTH];

`ifdef AUDIO_DELAY_ECHO_EN
    logic signed [32:0] wet_sum;
    assign wet_sum = sat_add(32'(dry), 32'(delayed >>> s1_shift), DATA_WIDTH);
    assign mixed   = s1_primed ? wet_sum[DATA_WIDTH-1:0] : dry;
`else
    assign mixed   = s1_primed ? delayed : '0;
`endif

    assign mix_frame[gi*DATA_WIDTH +: DATA_WIDTH] = mixed;
  end

`ifndef AUDIO_DELAY_ECHO_EN
  logic unused_shift;
  assign unused_shift = ^s1_shift;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      primed    <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= mix_frame;
        primed   <= s1_primed;
      end
    end
  end

endmodule

// File: tb/tb_audio_delay_line.sv
// Directed self-checking bench for audio_delay_line (DEPTH=32, two 16-bit channels).
// Echo checks are compiled in when AUDIO_DELAY_ECHO_EN is defined.
module tb_audio_delay_line;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [4:0]  delay = '0;
  logic        flush = 1'b0;
`ifdef AUDIO_DELAY_ECHO_EN
  logic [3:0]  echo_shift = '0;
`endif
  logic        out_valid;
  logic [31:0] out_data;
  logic        primed;
  logic [5:0]  fill_level;

  int checks = 0;
  int failures = 0;

  logic [15:0] stim_d0 [64];
  logic [15:0] stim_d1 [64];
  logic [4:0]  stim_dl [64];
  logic        stim_fl [64];
  logic        cap_v   [64];
  logic        cap_p   [64];
  logic [15:0] cap_d0  [64];
  logic [15:0] cap_d1  [64];

  audio_delay_line #(
    .DATA_WIDTH (16),
    .ADDR_WIDTH (5),
    .CHANNELS   (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .delay      (delay),
    .flush      (flush),
`ifdef AUDIO_DELAY_ECHO_EN
    .echo_shift (echo_shift),
`endif
    .out_valid  (out_valid),
    .out_data   (out_data),
    .primed     (primed),
    .fill_level (fill_level)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    delay = '0;
    in_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives n back-to-back strobes and captures each frame's output two cycles later.
  task automatic run_stream(input int n);
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        cap_v[i-2]  = out_valid;
        cap_p[i-2]  = primed;
        cap_d0[i-2] = out_data[15:0];
        cap_d1[i-2] = out_data[31:16];
      end
      if (i < n) begin
        in_valid = 1'b1;
        in_data  = {stim_d1[i], stim_d0[i]};
        delay    = stim_dl[i];
        flush    = stim_fl[i];
      end else begin
        in_valid = 1'b0;
        flush    = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({out_valid, primed, out_data, fill_level} !== 40'd0) begin
      failures++;
      $display("FAIL reset: out_valid=%b primed=%b out_data=%h fill_level=%0d, required all zero",
               out_valid, primed, out_data, fill_level);
    end else $display("reset: outputs zero");
  endtask

  task automatic test_delay4();
    logic [15:0] e0, e1;
    logic        ep;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      stim_d0[n] = 16'(n);
      stim_d1[n] = 16'(-n);
      stim_dl[n] = 5'd4;
      stim_fl[n] = 1'b0;
    end
    run_stream(40);
    for (int n = 0; n < 40; n++) begin
      ep = (n >= 4);
      e0 = ep ? 16'(n - 4) : 16'd0;
      e1 = ep ? 16'(-(n - 4)) : 16'd0;
      checks++;
      if ({cap_v[n], cap_p[n], cap_d1[n], cap_d0[n]} !== {1'b1, ep, e1, e0}) begin
        failures++;
        $display("FAIL delay4 n=%0d: got v=%b p=%b ch1=%h ch0=%h, required v=1 p=%b ch1=%h ch0=%h",
                 n, cap_v[n], cap_p[n], cap_d1[n], cap_d0[n], ep, e1, e0);
      end else $display("delay4 n=%0d: ch1=%h ch0=%h primed=%b", n, cap_d1[n], cap_d0[n], cap_p[n]);
    end
    checks++;
    if (fill_level !== 6'd32) begin
      failures++;
      $display("FAIL delay4_fill: fill_level=%0d, required 32", fill_level);
    end else $display("delay4: fill_level saturated at 32");
  endtask

  task automatic test_bypass();
    do_reset();
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'hABCD_1234;
    delay    = 5'd0;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bypass_early: out_valid=%b at t+1, required 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, primed, out_data} !== {2'b11, 32'hABCD_1234}) begin
      failures++;
      $display("FAIL bypass: v=%b p=%b data=%h, required v=1 p=1 data=abcd1234",
               out_valid, primed, out_data);
    end else $display("bypass: data=%h at t+2", out_data);
    @(negedge clk);
    checks++;
    if ({out_valid, primed, out_data} !== {2'b01, 32'hABCD_1234}) begin
      failures++;
      $display("FAIL bypass_hold: v=%b p=%b data=%h, required v=0 p=1 data=abcd1234",
               out_valid, primed, out_data);
    end else $display("bypass: output held, out_valid low");
  endtask

  task automatic test_wrap_and_flush();
    logic [15:0] e0;
    logic        ep;
    do_reset();
    for (int k = 0; k < 35; k++) begin
      stim_d0[k] = 16'(16'h0100 + k);
      stim_d1[k] = 16'(16'h0200 + k);
      stim_dl[k] = 5'd31;
      stim_fl[k] = 1'b0;
    end
    stim_dl[33] = 5'd1;
    stim_dl[34] = 5'd3;
    run_stream(35);
    // frame index expected at each captured slot (-1 = not primed)
    for (int k = 30; k < 35; k++) begin
      int src;
      src = (k == 30) ? -1 : (k == 31) ? 0 : (k == 32) ? 1 : (k == 33) ? 32 : 31;
      ep = (src >= 0);
      e0 = ep ? 16'(16'h0100 + src) : 16'd0;
      checks++;
      if ({cap_v[k], cap_p[k], cap_d0[k]} !== {1'b1, ep, e0}) begin
        failures++;
        $display("FAIL wrap k=%0d: got v=%b p=%b ch0=%h, required v=1 p=%b ch0=%h",
                 k, cap_v[k], cap_p[k], cap_d0[k], ep, e0);
      end else $display("wrap k=%0d: ch0=%h primed=%b", k, cap_d0[k], cap_p[k]);
    end
    checks++;
    if (fill_level !== 6'd32) begin
      failures++;
      $display("FAIL wrap_fill: fill_level=%0d, required 32", fill_level);
    end else $display("wrap: fill_level=32");

    for (int k = 0; k < 3; k++) begin
      stim_d0[k] = 16'(16'h0300 + k);
      stim_d1[k] = 16'(16'h0400 + k);
      stim_dl[k] = 5'd2;
      stim_fl[k] = (k == 0);
    end
    run_stream(3);
    for (int k = 0; k < 3; k++) begin
      ep = (k == 2);
      e0 = ep ? 16'h0300 : 16'd0;
      checks++;
      if ({cap_v[k], cap_p[k], cap_d0[k]} !== {1'b1, ep, e0}) begin
        failures++;
        $display("FAIL flush k=%0d: got v=%b p=%b ch0=%h, required v=1 p=%b ch0=%h",
                 k, cap_v[k], cap_p[k], cap_d0[k], ep, e0);
      end else $display("flush k=%0d: ch0=%h primed=%b", k, cap_d0[k], cap_p[k]);
    end
    checks++;
    if (fill_level !== 6'd3) begin
      failures++;
      $display("FAIL flush_fill: fill_level=%0d, required 3", fill_level);
    end else $display("flush: fill_level=3");
  endtask

  task automatic test_reset_inflight();
    int seen;
    do_reset();
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h5555_AAAA;
    delay    = 5'd0;
    @(negedge clk);
    in_data  = 32'h1111_2222;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checks++;
    if ({out_valid, primed, out_data} !== 34'd0) begin
      failures++;
      $display("FAIL reset_async: v=%b p=%b data=%h, required all zero", out_valid, primed, out_data);
    end else $display("reset_inflight: outputs cleared immediately");
    seen = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL reset_cancel: out_valid high on %0d cycles, required 0", seen);
    end else $display("reset_inflight: pending strobe cancelled");
  endtask

`ifdef AUDIO_DELAY_ECHO_EN
  task automatic test_echo();
    logic [15:0] exp0 [4];
    do_reset();
    echo_shift = 4'd1;
    stim_d0[0] = 16'h4000; stim_dl[0] = 5'd0;
    stim_d0[1] = 16'h7000; stim_dl[1] = 5'd1;
    stim_d0[2] = 16'h8000; stim_dl[2] = 5'd0;
    stim_d0[3] = 16'h8000; stim_dl[3] = 5'd1;
    for (int k = 0; k < 4; k++) begin
      stim_d1[k] = stim_d0[k];
      stim_fl[k] = 1'b0;
    end
    exp0[0] = 16'h6000;
    exp0[1] = 16'h7FFF;
    exp0[2] = 16'h8000;
    exp0[3] = 16'h8000;
    run_stream(4);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({cap_v[k], cap_p[k], cap_d1[k], cap_d0[k]} !== {2'b11, exp0[k], exp0[k]}) begin
        failures++;
        $display("FAIL echo k=%0d: got v=%b p=%b ch1=%h ch0=%h, required v=1 p=1 both %h",
                 k, cap_v[k], cap_p[k], cap_d1[k], cap_d0[k], exp0[k]);
      end else $display("echo k=%0d: out=%h", k, cap_d0[k]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_delay4();
    test_bypass();
    test_wrap_and_flush();
    test_reset_inflight();
`ifdef AUDIO_DELAY_ECHO_EN
    test_echo();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
